// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem bus controller.
//   state_e            controller state encoding (IDLE -> REQ -> DONE)
//   PAGE_DEFAULT       addr[31:24] value of the peripheral page
//   ERR_RDATA_DEFAULT  read data returned for unmapped or timed-out accesses
//   CNT_W              width of the watchdog counter (TIMEOUT up to 65535)
//   slave_idx_w()      bits needed to number NSLAVES slaves
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } state_e;

  localparam logic [7:0]  PAGE_DEFAULT      = 8'h03;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;
  localparam int unsigned CNT_W             = 16;

  function automatic int unsigned slave_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iomem_decode.sv
// Combinational address decoder for the peripheral page.
// Slave i lives at addr[31:16] == {PAGE, i[7:0]}.
//   addr_hi_i  in   16       master address bits [31:16]
//   hit_o      out  1        address maps onto an existing slave
//   sel_o      out  NSLAVES  one-hot slave select (all zero on a miss)
module iomem_decode
  import iomem_pkg::*;
#(
  parameter int unsigned NSLAVES = 4,
  parameter logic [7:0]  PAGE    = PAGE_DEFAULT
) (
  input  logic [15:0]        addr_hi_i,
  output logic               hit_o,
  output logic [NSLAVES-1:0] sel_o
);

  always_comb begin
    // Compare the slave number at 32 bits so NSLAVES up to 256 works.
    hit_o = (addr_hi_i[15:8] == PAGE) && ({24'd0, addr_hi_i[7:0]} < NSLAVES);
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    sel_o = '0;
    for (int i = 0; i < int'(NSLAVES); i++) begin
      sel_o[i] = hit_o && (addr_hi_i[7:0] == 8'(i));
    end
  end

endmodule

// File: rtl/iomem_ctrl.sv
// iomem bus controller: registers one master request at a time, forwards it
// to the decoded peripheral and returns a one-cycle m_ready_o pulse. A
// watchdog aborts transactions the slave never acknowledges; unmapped and
// timed-out accesses set a sticky error flag and capture the address.
//   clk_i      in   1           system clock
//   rst_i      in   1           asynchronous reset, active-high
//   m_valid_i  in   1           master request, held until m_ready_o
//   m_ready_o  out  1           one-cycle completion pulse
//   m_addr_i   in   32          master address
//   m_wdata_i  in   32          master write data
//   m_wstrb_i  in   4           byte strobes, 0 = read
//   m_rdata_o  out  32          read data, valid while m_ready_o
//   s_valid_o  out  NSLAVES     one-hot slave request
//   s_ready_i  in   NSLAVES     slave acknowledges
//   s_addr_o   out  32          registered address
//   s_wdata_o  out  32          registered write data
//   s_wstrb_o  out  4           registered strobes
//   s_rdata_i  in   32*NSLAVES  slave read data, slave i at [32*i+:32]
//   err_clr_i  in   1           clears err_flag_o / err_addr_o
//   err_flag_o out  1           sticky error flag
//   err_addr_o out  32          address of the latest failing access
module iomem_ctrl
  import iomem_pkg::*;
#(
  parameter int unsigned NSLAVES   = 4,
  parameter logic [7:0]  PAGE      = PAGE_DEFAULT,
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m_valid_i,
  output logic                    m_ready_o,
  input  logic [31:0]             m_addr_i,
  input  logic [31:0]             m_wdata_i,
  input  logic [3:0]              m_wstrb_i,
  output logic [31:0]             m_rdata_o,
  output logic [NSLAVES-1:0]      s_valid_o,
  input  logic [NSLAVES-1:0]      s_ready_i,
  output logic [31:0]             s_addr_o,
  output logic [31:0]             s_wdata_o,
  output logic [3:0]              s_wstrb_o,
  input  logic [32*NSLAVES-1:0]   s_rdata_i,
  input  logic                    err_clr_i,
  output logic                    err_flag_o,
  output logic [31:0]             err_addr_o
);

  state_e               state_q, state_d;
  logic [NSLAVES-1:0]   sel_q, sel_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_flag_q, err_flag_d;
  logic [31:0]          err_addr_q, err_addr_d;

  logic                 dec_hit;
  logic [NSLAVES-1:0]   dec_sel;
  logic [31:0]          rdata_sel;
  logic                 acked;

  iomem_decode #(
    .NSLAVES (NSLAVES),
    .PAGE    (PAGE)
  ) u_decode (
    .addr_hi_i (m_addr_i[31:16]),
    .hit_o     (dec_hit),
    .sel_o     (dec_sel)
  );

  // One-hot AND-OR mux of the selected slave's read data.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < int'(NSLAVES); i++) begin
      if (sel_q[i]) rdata_sel = rdata_sel | s_rdata_i[32*i +: 32];
    end
  end

  // Acks on non-selected slave lines are masked off here.
  assign acked = |(s_ready_i & sel_q);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;

    // Clear first; a failure below in the same cycle overrides it.
    if (err_clr_i) begin
      err_flag_d = 1'b0;
      err_addr_d = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (m_valid_i) begin
          addr_d  = m_addr_i;
          wdata_d = m_wdata_i;
          wstrb_d = m_wstrb_i;
          cnt_d   = '0;
          if (dec_hit) begin
            sel_d   = dec_sel;
            state_d = ST_REQ;
          end else begin
            rdata_d    = ERR_RDATA;
            err_flag_d = 1'b1;
            err_addr_d = m_addr_i;
            state_d    = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        // Ready is tested before the watchdog so a last-cycle ack still wins.
        if (acked) begin
          rdata_d = rdata_sel;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d    = ERR_RDATA;
          err_flag_d = 1'b1;
          err_addr_d = addr_q;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Decoded from state so an asynchronous reset drops them immediately.
  assign s_valid_o  = (state_q == ST_REQ) ? sel_q : '0;
  assign m_ready_o  = (state_q == ST_DONE);
  assign m_rdata_o  = rdata_q;
  assign s_addr_o   = addr_q;
  assign s_wdata_o  = wdata_q;
  assign s_wstrb_o  = wstrb_q;
  assign err_flag_o = err_flag_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_iomem_ctrl.sv
// Self-checking bench for iomem_ctrl: directed scenarios followed by random
// transactions, each scored against a transaction-level model of latency,
// returned data, slave request length and sticky error state.
module tb_iomem_ctrl;

  localparam int          NS   = 4;
  localparam int          TO   = 64;
  localparam logic [7:0]  PG   = 8'h03;
  localparam logic [31:0] ERRV = 32'hFFFF_FFFF;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              m_valid_i;
  logic              m_ready_o;
  logic [31:0]       m_addr_i;
  logic [31:0]       m_wdata_i;
  logic [3:0]        m_wstrb_i;
  logic [31:0]       m_rdata_o;
  logic [NS-1:0]     s_valid_o;
  logic [NS-1:0]     s_ready_i;
  logic [31:0]       s_addr_o;
  logic [31:0]       s_wdata_o;
  logic [3:0]        s_wstrb_o;
  logic [32*NS-1:0]  s_rdata_i;
  logic              err_clr_i;
  logic              err_flag_o;
  logic [31:0]       err_addr_o;

  int n_total = 0;
  int n_bad   = 0;

  // Expected sticky error state.
  logic        exp_ef;
  logic [31:0] exp_ea;

  // Slave responder: ack once s_valid has been high for wait_n cycles;
  // noise drives ready on the non-selected lines.
  int            vcnt;
  int            wait_n;
  logic [NS-1:0] noise;

  iomem_ctrl #(
    .NSLAVES   (NS),
    .PAGE      (PG),
    .TIMEOUT   (TO),
    .ERR_RDATA (ERRV)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m_valid_i  (m_valid_i),
    .m_ready_o  (m_ready_o),
    .m_addr_i   (m_addr_i),
    .m_wdata_i  (m_wdata_i),
    .m_wstrb_i  (m_wstrb_i),
    .m_rdata_o  (m_rdata_o),
    .s_valid_o  (s_valid_o),
    .s_ready_i  (s_ready_i),
    .s_addr_o   (s_addr_o),
    .s_wdata_o  (s_wdata_o),
    .s_wstrb_o  (s_wstrb_o),
    .s_rdata_i  (s_rdata_i),
    .err_clr_i  (err_clr_i),
    .err_flag_o (err_flag_o),
    .err_addr_o (err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i)               vcnt <= 0;
    else if (s_valid_o != 0) vcnt <= vcnt + 1;
    else                     vcnt <= 0;
  end

  always_comb s_ready_i = (s_valid_o & {NS{vcnt == wait_n}}) | (noise & ~s_valid_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One master transaction, started on a negedge. w = slave wait cycles,
  // clr_at = cycle (0 = request cycle) during which err_clr is high, -1 none.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input int w, input int clr_at, input bit scr,
                        input bit frc, input logic [31:0] frc_rd);
    bit            mapped;
    bit            fail;
    int            idx;
    int            exp_done;
    int            exp_sv;
    logic [31:0]   exp_rd;
    logic [NS-1:0] exp_sel;
    int            cyc;
    int            svc;
    bit            got;

    mapped = (a[31:24] == PG) && (int'(a[23:16]) < NS);
    idx    = int'(a[23:16]);
    for (int i = 0; i < NS; i++) s_rdata_i[32*i +: 32] = $urandom;
    if (mapped && frc) s_rdata_i[32*idx +: 32] = frc_rd;

    exp_sel = '0;
    if (!mapped) begin
      exp_done = 1;      exp_sv = 0;  exp_rd = ERRV; fail = 1'b1;
    end else if (w <= TO - 1) begin
      exp_done = w + 2;  exp_sv = w + 1; exp_rd = s_rdata_i[32*idx +: 32]; fail = 1'b0;
      exp_sel[idx] = 1'b1;
    end else begin
      exp_done = TO + 1; exp_sv = TO; exp_rd = ERRV; fail = 1'b1;
      exp_sel[idx] = 1'b1;
    end

    m_valid_i = 1'b1;
    m_addr_i  = a;
    m_wdata_i = wd;
    m_wstrb_i = ws;
    wait_n    = w;
    noise     = NS'($urandom);
    err_clr_i = (clr_at == 0);
    cyc = 0; svc = 0; got = 1'b0;

    while (!got && cyc < TO + 8) begin
      @(posedge clk_i); #1;
      cyc++;
      if (s_valid_o != 0) begin
        svc++;
        check("s_valid", 32'(s_valid_o), 32'(exp_sel));
        check("s_addr", s_addr_o, a);
        check("s_wdata", s_wdata_o, wd);
        check("s_wstrb", 32'(s_wstrb_o), 32'(ws));
      end
      if (m_ready_o) got = 1'b1;
      else if (scr) begin
        m_addr_i  = $urandom;
        m_wdata_i = $urandom;
        m_wstrb_i = 4'($urandom);
        m_valid_i = 1'($urandom_range(0, 1));
      end
      err_clr_i = (cyc == clr_at);
      noise     = NS'($urandom);
    end

    check("done_cycle", got ? 32'(cyc) : 32'hDEAD_BEEF, 32'(exp_done));
    check("m_rdata", m_rdata_o, exp_rd);
    check("s_valid_cycles", 32'(svc), 32'(exp_sv));

    // Model: a clear after the failing edge wins, otherwise set wins.
    if (fail) begin
      if (clr_at > exp_done - 1) begin exp_ef = 1'b0; exp_ea = '0; end
      else                       begin exp_ef = 1'b1; exp_ea = a;  end
    end else if (clr_at >= 0) begin
      exp_ef = 1'b0; exp_ea = '0;
    end

    m_valid_i = 1'b0;
    @(posedge clk_i); #1;
    err_clr_i = 1'b0;
    noise     = '0;
    check("m_ready_pulse", 32'(m_ready_o), 32'd0);
    check("m_rdata_hold", m_rdata_o, exp_rd);
    check("err_flag", 32'(err_flag_o), 32'(exp_ef));
    check("err_addr", err_addr_o, exp_ea);
    @(negedge clk_i);
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    @(posedge clk_i); #1;
    err_clr_i = 1'b0;
    exp_ef = 1'b0;
    exp_ea = '0;
    check("clr_flag", 32'(err_flag_o), 32'd0);
    check("clr_addr", err_addr_o, 32'd0);
    @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  hb;
    int          w;
    int          clr;

    rst_i = 1'b1; m_valid_i = 1'b0; m_addr_i = '0; m_wdata_i = '0; m_wstrb_i = '0;
    s_rdata_i = '0; err_clr_i = 1'b0; wait_n = 0; noise = '0;
    exp_ef = 1'b0; exp_ea = '0;

    repeat (2) @(negedge clk_i);
    check("rst_m_ready", 32'(m_ready_o), 32'd0);
    check("rst_s_valid", 32'(s_valid_o), 32'd0);
    check("rst_s_addr", s_addr_o, 32'd0);
    check("rst_s_wdata", s_wdata_o, 32'd0);
    check("rst_s_wstrb", 32'(s_wstrb_o), 32'd0);
    check("rst_m_rdata", m_rdata_o, 32'd0);
    check("rst_err_flag", 32'(err_flag_o), 32'd0);
    check("rst_err_addr", err_addr_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Read slave 0 with immediate ready.
    do_txn(32'h0300_0004, 32'h0, 4'h0, 0, -1, 1'b0, 1'b1, 32'h1234_5678);
    // Write slave 2 after three wait cycles.
    do_txn(32'h0302_0000, 32'hA5A5_A5A5, 4'hF, 3, -1, 1'b0, 1'b0, 32'h0);
    // Unmapped page.
    do_txn(32'h0400_0000, 32'h0, 4'h0, 0, -1, 1'b0, 1'b0, 32'h0);
    // Slave 1 never acks: watchdog.
    do_txn(32'h0301_0000, 32'h0, 4'h0, 1000, -1, 1'b0, 1'b0, 32'h0);
    pulse_clr();
    // Ack on the final watchdog cycle wins.
    do_txn(32'h0301_0008, 32'h0, 4'h0, TO - 1, -1, 1'b0, 1'b0, 32'h0);
    // err_clr together with a timeout: set wins.
    do_txn(32'h0303_0010, 32'h0, 4'h0, 1000, TO, 1'b0, 1'b0, 32'h0);
    pulse_clr();
    // Slave number just past the last slave, and master scrambling mid-REQ.
    do_txn(32'h0304_0000, 32'h0, 4'h0, 0, -1, 1'b0, 1'b0, 32'h0);
    do_txn(32'h0303_0020, 32'h5555_AAAA, 4'h3, 5, -1, 1'b1, 1'b0, 32'h0);

    // Reset in the middle of a slave request.
    m_valid_i = 1'b1; m_addr_i = 32'h0301_0010; m_wstrb_i = 4'h0; wait_n = 1000;
    repeat (5) @(negedge clk_i);
    check("pre_rst_s_valid", 32'(s_valid_o), 32'h2);
    rst_i = 1'b1;
    #1;
    check("mid_rst_s_valid", 32'(s_valid_o), 32'd0);
    check("mid_rst_m_ready", 32'(m_ready_o), 32'd0);
    check("mid_rst_err_flag", 32'(err_flag_o), 32'd0);
    exp_ef = 1'b0; exp_ea = '0;
    m_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    do_txn(32'h0302_0004, 32'h0, 4'h0, 1, -1, 1'b0, 1'b0, 32'h0);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      hb = ($urandom_range(0, 9) == 0) ? 8'($urandom) : PG;
      a  = {hb, 8'($urandom_range(0, 5)), 16'($urandom)};
      case ($urandom_range(0, 7))
        0:       w = TO - 2 + $urandom_range(0, 3);
        default: w = $urandom_range(0, 4);
      endcase
      clr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : -1;
      do_txn(a, $urandom, 4'($urandom), w, clr, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
